// File: rtl/fir_stream_reload_if.sv
// Stream, coefficient-load and status signals of the reloadable FIR.
// The master drives samples and coefficient words; the slave is the filter.
interface fir_stream_reload_if #(
    parameter int DATA_W = 16,
    parameter int COE_W  = 16,
    parameter int OUT_W  = 16
);
    logic signed [DATA_W-1:0] i_data;
    logic                     i_vld;
    logic signed [COE_W-1:0]  i_coe;
    logic                     i_coe_vld;
    logic                     i_coe_last;
    logic signed [OUT_W-1:0]  o_data;
    logic                     o_vld;
    logic                     o_sat;
    logic                     o_coe_err;
    logic                     o_bank;

    modport master (
        output i_data, i_vld, i_coe, i_coe_vld, i_coe_last,
        input  o_data, o_vld, o_sat, o_coe_err, o_bank
    );

    modport slave (
        input  i_data, i_vld, i_coe, i_coe_vld, i_coe_last,
        output o_data, o_vld, o_sat, o_coe_err, o_bank
    );
endinterface

// File: rtl/fir_stream_reload.sv
// Streaming FIR with aligned valid, double-buffered coefficient reload and
// round/saturate to OUT_W. Optional symmetric pre-add halves the multipliers.
module fir_stream_reload #(
    parameter int DATA_W    = 16,
    parameter int COE_W     = 16,
    parameter int TAPS      = 17,
    parameter int SYMMETRIC = 0,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 15
) (
    input logic                clk,
    input logic                reset,
    fir_stream_reload_if.slave bus
);
    localparam int SYM     = (SYMMETRIC != 0) ? 1 : 0;
    localparam int N_LOAD  = (SYM != 0) ? (TAPS + 1) / 2 : TAPS;
    localparam int LVL     = $clog2(N_LOAD);
    localparam int NP      = 1 << LVL;
    localparam int PRE_W   = DATA_W + SYM;
    localparam int PROD_W  = PRE_W + COE_W;
    localparam int ACC_W   = DATA_W + COE_W + SYM + LVL;
    localparam int L       = 5 + LVL;
    localparam int CNT_W   = (N_LOAD > 1) ? $clog2(N_LOAD) : 1;
    localparam int RND_BIT = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(N_LOAD - 1);
    localparam logic signed [ACC_W:0] MAX_V =
        {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN_V =
        {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    // Returns {sat, value}: round-half-up shift, then clip to OUT_W.
    function automatic logic [OUT_W:0] round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W:0] half;
        logic signed [ACC_W:0] r;
        half = '0;
        if (OUT_SHIFT > 0) half[RND_BIT] = 1'b1;
        r = ($signed({acc[ACC_W-1], acc}) + half) >>> OUT_SHIFT;
        if (r > MAX_V)      return {1'b1, 1'b0, {(OUT_W - 1){1'b1}}};
        else if (r < MIN_V) return {1'b1, 1'b1, {(OUT_W - 1){1'b0}}};
        else                return {1'b0, r[OUT_W-1:0]};
    endfunction

    logic signed [COE_W-1:0]  shadow  [N_LOAD];
    logic signed [COE_W-1:0]  active  [N_LOAD];
    logic signed [COE_W-1:0]  coe_use [N_LOAD];
    logic [CNT_W-1:0]         cnt;
    logic                     swap_pend;
    logic                     coe_err;
    logic                     bank;

    logic signed [DATA_W-1:0] line_p0 [TAPS];
    logic signed [PRE_W-1:0]  pre_p1  [N_LOAD];
    logic signed [PROD_W-1:0] mul_p2  [N_LOAD];
    logic signed [ACC_W-1:0]  tree_p3 [LVL+1][NP];
    logic [L-1:0]             vld_p;
    logic signed [OUT_W-1:0]  data_q;
    logic                     sat_q;

    wire at_last = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            swap_pend <= 1'b0;
            coe_err   <= 1'b0;
            bank      <= 1'b0;
            for (int k = 0; k < N_LOAD; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            swap_pend <= 1'b0;
            if (swap_pend) begin
                active <= shadow;
                bank   <= ~bank;
            end
            if (bus.i_coe_vld) begin
                if (bus.i_coe_last) begin
                    shadow[cnt] <= bus.i_coe;
                    cnt         <= '0;
                    if (at_last) swap_pend <= 1'b1;
                    else         coe_err   <= 1'b1;
                end else if (at_last) begin
                    coe_err <= 1'b1;
                end else begin
                    shadow[cnt] <= bus.i_coe;
                    cnt         <= cnt + 1'b1;
                end
            end
        end
    end

    // While a swap is pending the completed shadow set is already the one to use,
    // so the sample whose multiply lands on the swap edge sees the new bank.
    always_comb begin
        for (int k = 0; k < N_LOAD; k++)
            coe_use[k] = swap_pend ? shadow[k] : active[k];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p  <= '0;
            data_q <= '0;
            sat_q  <= 1'b0;
            for (int k = 0; k < TAPS; k++) line_p0[k] <= '0;
            for (int k = 0; k < N_LOAD; k++) begin
                pre_p1[k] <= '0;
                mul_p2[k] <= '0;
            end
            for (int l = 0; l <= LVL; l++)
                for (int i = 0; i < NP; i++) tree_p3[l][i] <= '0;
        end else begin
            // p0: delay line advances only on accepted samples
            if (bus.i_vld) begin
                line_p0[0] <= bus.i_data;
                for (int k = 1; k < TAPS; k++) line_p0[k] <= line_p0[k-1];
            end
            // p1: symmetric pre-add, middle/unfolded taps pass through
            for (int k = 0; k < N_LOAD; k++) begin
                if (SYM != 0 && k < TAPS / 2)
                    pre_p1[k] <= PRE_W'(line_p0[k]) + PRE_W'(line_p0[TAPS-1-k]);
                else
                    pre_p1[k] <= PRE_W'(line_p0[k]);
            end
            // p2: multiply
            for (int k = 0; k < N_LOAD; k++)
                mul_p2[k] <= PROD_W'(pre_p1[k]) * PROD_W'(coe_use[k]);
            // p3: product register (tree level 0), then LVL registered adder levels
            for (int i = 0; i < NP; i++) tree_p3[0][i] <= '0;
            for (int k = 0; k < N_LOAD; k++) tree_p3[0][k] <= ACC_W'(mul_p2[k]);
            for (int l = 1; l <= LVL; l++)
                for (int i = 0; i < (NP >> l); i++)
                    tree_p3[l][i] <= tree_p3[l-1][2*i] + tree_p3[l-1][2*i+1];
            // output: round/saturate; data holds between valid outputs
            vld_p <= {vld_p[L-2:0], bus.i_vld};
            if (vld_p[L-2]) {sat_q, data_q} <= round_sat(tree_p3[LVL][0]);
            else            sat_q <= 1'b0;
        end
    end

    assign bus.o_data    = data_q;
    assign bus.o_vld     = vld_p[L-1];
    assign bus.o_sat     = sat_q;
    assign bus.o_coe_err = coe_err;
    assign bus.o_bank    = bank;
endmodule

// File: tb/tb_fir_stream_reload.sv
// Directed bench for fir_stream_reload: four configurations driven from shared
// stimulus signals, each output compared cycle by cycle with hand-derived values.
module tb_fir_stream_reload;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic signed [15:0] din;
    logic               dvld;
    logic [3:0]         dsel;
    logic signed [15:0] coe;
    logic               cvld, clast;
    logic [3:0]         csel;

    fir_stream_reload_if #(.DATA_W(16), .COE_W(16), .OUT_W(16)) if0 ();
    fir_stream_reload_if #(.DATA_W(16), .COE_W(16), .OUT_W(16)) if1 ();
    fir_stream_reload_if #(.DATA_W(16), .COE_W(16), .OUT_W(16)) if2 ();
    fir_stream_reload_if #(.DATA_W(16), .COE_W(16), .OUT_W(16)) if3 ();

    // u0: 4 taps plain; u1: 5 taps symmetric; u2: 4 taps shift 15; u3: 2 taps shift 2
    fir_stream_reload #(.DATA_W(16), .COE_W(16), .TAPS(4), .SYMMETRIC(0), .OUT_W(16), .OUT_SHIFT(0))
        u0 (.clk(clk), .reset(reset), .bus(if0.slave));
    fir_stream_reload #(.DATA_W(16), .COE_W(16), .TAPS(5), .SYMMETRIC(1), .OUT_W(16), .OUT_SHIFT(0))
        u1 (.clk(clk), .reset(reset), .bus(if1.slave));
    fir_stream_reload #(.DATA_W(16), .COE_W(16), .TAPS(4), .SYMMETRIC(0), .OUT_W(16), .OUT_SHIFT(15))
        u2 (.clk(clk), .reset(reset), .bus(if2.slave));
    fir_stream_reload #(.DATA_W(16), .COE_W(16), .TAPS(2), .SYMMETRIC(0), .OUT_W(16), .OUT_SHIFT(2))
        u3 (.clk(clk), .reset(reset), .bus(if3.slave));

    assign if0.i_data = din;  assign if0.i_vld = dvld & dsel[0];
    assign if1.i_data = din;  assign if1.i_vld = dvld & dsel[1];
    assign if2.i_data = din;  assign if2.i_vld = dvld & dsel[2];
    assign if3.i_data = din;  assign if3.i_vld = dvld & dsel[3];
    assign if0.i_coe = coe;   assign if0.i_coe_vld = cvld & csel[0];  assign if0.i_coe_last = clast;
    assign if1.i_coe = coe;   assign if1.i_coe_vld = cvld & csel[1];  assign if1.i_coe_last = clast;
    assign if2.i_coe = coe;   assign if2.i_coe_vld = cvld & csel[2];  assign if2.i_coe_last = clast;
    assign if3.i_coe = coe;   assign if3.i_coe_vld = cvld & csel[3];  assign if3.i_coe_last = clast;

    typedef struct packed {
        logic        bank;
        logic        err;
        logic        sat;
        logic        vld;
        logic [15:0] data;
    } obs_t;

    function automatic obs_t obs(input int d);
        obs_t o;
        case (d)
            0: o = {if0.o_bank, if0.o_coe_err, if0.o_sat, if0.o_vld, if0.o_data};
            1: o = {if1.o_bank, if1.o_coe_err, if1.o_sat, if1.o_vld, if1.o_data};
            2: o = {if2.o_bank, if2.o_coe_err, if2.o_sat, if2.o_vld, if2.o_data};
            3: o = {if3.o_bank, if3.o_coe_err, if3.o_sat, if3.o_vld, if3.o_data};
            default: o = '0;
        endcase
        return o;
    endfunction

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Per-cycle stimulus and expected output tables
    int sx [40];
    bit sv [40];
    int ex [40];
    bit ev [40];
    bit es [40];

    task automatic clear_vec();
        for (int i = 0; i < 40; i++) begin
            sx[i] = 0; sv[i] = 1'b0; ex[i] = 0; ev[i] = 1'b0; es[i] = 1'b0;
        end
    endtask

    task automatic stim(input int c, input int x);
        sx[c] = x;
        sv[c] = 1'b1;
    endtask

    task automatic expect_out(input int c, input int x, input bit s);
        ev[c] = 1'b1;
        ex[c] = x;
        es[c] = s;
    endtask

    // Cycle c: compare outputs, then present sample c for the next rising edge.
    task automatic run(input int d, input int n, input int hold0, input string tag);
        obs_t o;
        int   hold;
        hold = hold0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            o = obs(d);
            if (ev[c]) hold = ex[c];
            check($sformatf("%s vld[%0d]", tag, c), int'(o.vld), int'(ev[c]));
            check($sformatf("%s data[%0d]", tag, c), int'($signed(o.data)), hold);
            check($sformatf("%s sat[%0d]", tag, c), int'(o.sat), int'(es[c]));
            din  = 16'(sx[c]);
            dvld = sv[c];
            dsel = 4'(1 << d);
        end
        dvld = 1'b0;
    endtask

    task automatic load(input int d, input int n, input bit last,
                        input int c0, input int c1, input int c2, input int c3);
        int w [4];
        w[0] = c0; w[1] = c1; w[2] = c2; w[3] = c3;
        csel = 4'(1 << d);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            coe   = 16'(w[i]);
            cvld  = 1'b1;
            clast = last && (i == n - 1);
        end
        @(negedge clk);
        cvld  = 1'b0;
        clast = 1'b0;
    endtask

    task automatic check_rst(input int d, input string tag);
        obs_t o;
        o = obs(d);
        check($sformatf("%s%0d data", tag, d), int'($signed(o.data)), 0);
        check($sformatf("%s%0d vld", tag, d), int'(o.vld), 0);
        check($sformatf("%s%0d sat", tag, d), int'(o.sat), 0);
        check($sformatf("%s%0d err", tag, d), int'(o.err), 0);
        check($sformatf("%s%0d bank", tag, d), int'(o.bank), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, limit 200000", $time);
        $fatal(1);
    end

    initial begin
        obs_t o;
        reset = 1'b1;
        din = '0; dvld = 1'b0; dsel = '0;
        coe = '0; cvld = 1'b0; clast = 1'b0; csel = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 4; d++) check_rst(d, "rst");

        // Plain 4-tap impulse response, latency 7
        load(0, 4, 1'b1, 1, 2, 3, 4);
        @(negedge clk);
        o = obs(0);
        check("load0 bank", int'(o.bank), 1);
        check("load0 err", int'(o.err), 0);
        clear_vec();
        stim(0, 1); stim(1, 0); stim(2, 0); stim(3, 0); stim(4, 0);
        expect_out(7, 1, 0); expect_out(8, 2, 0); expect_out(9, 3, 0);
        expect_out(10, 4, 0); expect_out(11, 0, 0);
        run(0, 14, 0, "imp");

        // Symmetric 5-tap with idle gaps between samples
        load(1, 3, 1'b1, 1, 2, 3, 0);
        @(negedge clk);
        clear_vec();
        stim(0, 100); stim(2, 0); stim(3, 0); stim(6, 0); stim(7, 0);
        expect_out(7, 100, 0); expect_out(9, 200, 0); expect_out(10, 300, 0);
        expect_out(13, 200, 0); expect_out(14, 100, 0);
        run(1, 17, 0, "sym");

        // Full-scale saturation both directions, plus unsaturated neighbours
        load(2, 4, 1'b1, 32767, 32767, 32767, 32767);
        @(negedge clk);
        clear_vec();
        for (int c = 0; c < 4; c++) stim(c, 32767);
        for (int c = 4; c < 8; c++) stim(c, -32768);
        expect_out(7, 32766, 0);
        for (int c = 8; c < 12; c++) expect_out(c, 32767, 1);
        expect_out(12, -2, 0);
        expect_out(13, -32768, 1); expect_out(14, -32768, 1);
        run(2, 17, 0, "sat");

        // Round-half-up with OUT_SHIFT=2, coefficients [1,0], latency 6
        load(3, 2, 1'b1, 1, 0, 0, 0);
        @(negedge clk);
        clear_vec();
        stim(0, 6); stim(1, -6); stim(2, 5); stim(3, 7); stim(4, -7); stim(5, -2);
        expect_out(6, 2, 0); expect_out(7, -1, 0); expect_out(8, 1, 0);
        expect_out(9, 2, 0); expect_out(10, -2, 0); expect_out(11, 0, 0);
        run(3, 14, 0, "rnd");

        // Overlong load: middle word dropped, final last word completes [3,1]
        load(3, 3, 1'b1, 3, 7, 1, 0);
        @(negedge clk);
        o = obs(3);
        check("ovl err", int'(o.err), 1);
        check("ovl bank", int'(o.bank), 0);
        clear_vec();
        stim(0, 4); stim(1, 0);
        expect_out(6, 3, 0); expect_out(7, 1, 0);
        run(3, 10, 0, "ovl");

        // Short load: error, no swap, old coefficients still in use
        load(0, 3, 1'b1, 9, 9, 9, 0);
        @(negedge clk);
        o = obs(0);
        check("short err", int'(o.err), 1);
        check("short bank", int'(o.bank), 1);
        clear_vec();
        stim(0, 1); stim(1, 0); stim(2, 0); stim(3, 0);
        expect_out(7, 1, 0); expect_out(8, 2, 0); expect_out(9, 3, 0); expect_out(10, 4, 0);
        run(0, 12, 0, "err");

        // Swap under traffic: last word at edge 8, samples from 7 on use [10,20,30,40]
        clear_vec();
        for (int n = 0; n < 16; n++) begin
            stim(n, (n % 4 == 0) ? 1 : 0);
            expect_out(n + 7, (n < 7) ? (n % 4 + 1) : 10 * (n % 4 + 1), 0);
        end
        fork
            run(0, 24, 4, "swap");
            begin
                repeat (5) @(negedge clk);
                load(0, 4, 1'b1, 10, 20, 30, 40);
            end
        join
        @(negedge clk);
        o = obs(0);
        check("swap bank", int'(o.bank), 0);
        check("swap err", int'(o.err), 1);

        // Reset with three samples in flight
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            din = 16'sd5; dvld = 1'b1; dsel = 4'b0001;
        end
        @(negedge clk);
        dvld  = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 4; d++) check_rst(d, "mrst");
        clear_vec();
        run(0, 12, 0, "rstq");
        clear_vec();
        stim(0, 7);
        expect_out(7, 0, 0);
        run(0, 10, 0, "zcoe");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
